// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: the pipeline write always wins, and multi-cycle results
// wait in a small FIFO whose stale entries are squashed by newer pipeline writes.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pwe,
    input  logic [4:0]  pwn,
    input  logic [31:0] pd,
    input  logic        svalid,
    input  logic [4:0]  swn,
    input  logic [31:0] sd,
    output logic        sready,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic        pend_a,
    output logic        pend_b,
    output logic        we,
    output logic [4:0]  wn,
    output logic [31:0] d
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] live_q;
    logic [4:0]       ewn_q [DEPTH];
    logic [31:0]      ed_q  [DEPTH];
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;

    logic prim, push, push_live, pop;
    logic hit_a, hit_b;

    always_comb begin
        prim      = pwe && (pwn != 5'd0);
        sready    = !clr && (count_q != FULL);
        push      = svalid && sready && (swn != 5'd0);
        // A same-cycle pipeline write to the same register is younger, so the entry is born dead.
        push_live = !(pwe && (pwn == swn));
        pop       = !prim && (count_q != '0);
    end

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live_q[i] && ewn_q[i] == rna) hit_a = 1'b1;
            if (live_q[i] && ewn_q[i] == rnb) hit_b = 1'b1;
        end
        pend_a = !clr && (rna != 5'd0) && (hit_a || (push && push_live && swn == rna));
        pend_b = !clr && (rnb != 5'd0) && (hit_b || (push && push_live && swn == rnb));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we      <= 1'b0;
            wn      <= 5'd0;
            d       <= 32'd0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (prim && ewn_q[i] == pwn) live_q[i] <= 1'b0;
            end
            // Popped slots are marked dead so hazard lookup only sees occupied entries.
            if (pop) begin
                live_q[head_q] <= 1'b0;
                head_q         <= head_q + 1'b1;
            end
            if (push) begin
                live_q[tail_q] <= push_live;
                ewn_q[tail_q]  <= swn;
                ed_q[tail_q]   <= sd;
                tail_q         <= tail_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (prim) begin
                we <= 1'b1;
                wn <= pwn;
                d  <= pd;
            end else if (pop) begin
                we <= live_q[head_q];
                wn <= ewn_q[head_q];
                d  <= ed_q[head_q];
            end else begin
                we <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, primary path, queueing, squash, conflicts, mid-run reset.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        clr, pwe, svalid;
    logic [4:0]  pwn, swn, rna, rnb, wn;
    logic [31:0] pd, sd, d;
    logic        sready, pend_a, pend_b, we;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .clr(clr), .pwe(pwe), .pwn(pwn), .pd(pd),
        .svalid(svalid), .swn(swn), .sd(sd), .sready(sready),
        .rna(rna), .rnb(rnb), .pend_a(pend_a), .pend_b(pend_b),
        .we(we), .wn(wn), .d(d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1; pwe = 0; pwn = 0; pd = 0; svalid = 1; swn = 2; sd = 32'h55;
        rna = 0; rnb = 0;
        #1;
        total++; if (sready !== 1'b0) begin bad++; $display("FAIL reset_sready got=%b exp=0", sready); end
        tick(); tick();
        total++; if (sready !== 1'b0) begin bad++; $display("FAIL reset_sready2 got=%b exp=0", sready); end
        total++; if (we !== 1'b0 || wn !== 5'd0 || d !== 32'd0) begin
            bad++; $display("FAIL reset_out got=%b/%0d/%h exp=0/0/0", we, wn, d);
        end
        clr = 0; svalid = 0;
        #1;
        total++; if (sready !== 1'b1) begin bad++; $display("FAIL release_sready got=%b exp=1", sready); end
        total++; if (pend_a !== 1'b0 || pend_b !== 1'b0) begin
            bad++; $display("FAIL release_pend got=%b%b exp=00", pend_a, pend_b);
        end
    endtask

    task automatic test_primary();
        pwe = 1; pwn = 5; pd = 32'hDEADBEEF;
        tick();
        total++; if (we !== 1'b1 || wn !== 5'd5 || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL primary got=%b/%0d/%h exp=1/5/deadbeef", we, wn, d);
        end
        pwn = 0; pd = 32'h1;
        tick();
        total++; if (we !== 1'b0 || wn !== 5'd5 || d !== 32'hDEADBEEF) begin
            bad++; $display("FAIL primary_r0 got=%b/%0d/%h exp=0/5/deadbeef", we, wn, d);
        end
        pwe = 0;
    endtask

    task automatic test_queue();
        pwe = 1; pwn = 7; pd = 32'h700; svalid = 1;
        for (int i = 0; i < 6; i++) begin
            swn = (i < 4) ? 5'(i + 1) : 5'd5;
            sd  = 32'h100 + 32'(i);
            #1;
            total++; if (sready !== (i < 4)) begin
                bad++; $display("FAIL queue_sready[%0d] got=%b exp=%b", i, sready, (i < 4));
            end
            tick();
            total++; if (we !== 1'b1 || wn !== 5'd7 || d !== 32'h700) begin
                bad++; $display("FAIL queue_prim[%0d] got=%b/%0d/%h exp=1/7/700", i, we, wn, d);
            end
        end
        pwe = 0; svalid = 0; rna = 3; rnb = 6;
        #1;
        total++; if (pend_a !== 1'b1 || pend_b !== 1'b0) begin
            bad++; $display("FAIL queue_pend got=%b%b exp=10", pend_a, pend_b);
        end
        total++; if (sready !== 1'b0) begin bad++; $display("FAIL queue_full got=%b exp=0", sready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (we !== 1'b1 || wn !== 5'(k + 1) || d !== 32'h100 + 32'(k)) begin
                bad++; $display("FAIL drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, we, wn, d,
                                k + 1, 32'h100 + 32'(k));
            end
        end
        tick();
        total++; if (we !== 1'b0 || sready !== 1'b1 || pend_a !== 1'b0) begin
            bad++; $display("FAIL drain_end got=we%b/rdy%b/pa%b exp=0/1/0", we, sready, pend_a);
        end
        rna = 0; rnb = 0;
    endtask

    task automatic test_squash();
        svalid = 1; swn = 9; sd = 32'h11; rna = 9;
        #1;
        total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL squash_pend_in got=%b exp=1", pend_a); end
        tick();
        svalid = 0; pwe = 1; pwn = 9; pd = 32'h22;
        #1;
        total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL squash_pend_q got=%b exp=1", pend_a); end
        tick();
        total++; if (we !== 1'b1 || wn !== 5'd9 || d !== 32'h22) begin
            bad++; $display("FAIL squash_prim got=%b/%0d/%h exp=1/9/22", we, wn, d);
        end
        pwe = 0;
        #1;
        total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL squash_pend_after got=%b exp=0", pend_a); end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL squash_dead_pop got=%b exp=0", we); end
        tick();
        total++; if (we !== 1'b0 || sready !== 1'b1) begin
            bad++; $display("FAIL squash_end got=we%b/rdy%b exp=0/1", we, sready);
        end
        rna = 0;
    endtask

    task automatic test_conflict();
        svalid = 1; swn = 3; sd = 32'hA; pwe = 1; pwn = 3; pd = 32'hB; rna = 3;
        #1;
        total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL conflict_pend got=%b exp=0", pend_a); end
        tick();
        total++; if (we !== 1'b1 || wn !== 5'd3 || d !== 32'hB) begin
            bad++; $display("FAIL conflict_prim got=%b/%0d/%h exp=1/3/b", we, wn, d);
        end
        pwe = 0; swn = 0; sd = 32'hC;
        #1;
        total++; if (pend_a !== 1'b0 || sready !== 1'b1) begin
            bad++; $display("FAIL conflict_q got=pa%b/rdy%b exp=0/1", pend_a, sready);
        end
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL conflict_dead got=%b exp=0", we); end
        svalid = 0;
        tick();
        total++; if (we !== 1'b0) begin bad++; $display("FAIL r0_issued got=%b exp=0", we); end
        tick();
        total++; if (we !== 1'b0 || sready !== 1'b1) begin
            bad++; $display("FAIL r0_end got=we%b/rdy%b exp=0/1", we, sready);
        end
        rna = 0;
    endtask

    task automatic test_midreset();
        pwe = 1; pwn = 7; pd = 32'h77; svalid = 1;
        for (int i = 0; i < 3; i++) begin
            swn = 5'(20 + i); sd = 32'h200 + 32'(i);
            tick();
        end
        clr = 1; pwe = 0; svalid = 0; rna = 20;
        #1;
        total++; if (sready !== 1'b0 || pend_a !== 1'b0) begin
            bad++; $display("FAIL midrst_comb got=rdy%b/pa%b exp=0/0", sready, pend_a);
        end
        tick();
        total++; if (we !== 1'b0 || wn !== 5'd0 || d !== 32'd0) begin
            bad++; $display("FAIL midrst_out got=%b/%0d/%h exp=0/0/0", we, wn, d);
        end
        clr = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (we !== 1'b0) begin bad++; $display("FAIL midrst_stale[%0d] got=%b exp=0", k, we); end
        end
        total++; if (sready !== 1'b1 || pend_a !== 1'b0) begin
            bad++; $display("FAIL midrst_end got=rdy%b/pa%b exp=1/0", sready, pend_a);
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_queue();
        test_squash();
        test_conflict();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter and buffer that drives the single write port (we, wn, d) of the CPU register file. It merges the in-order pipeline's write-back stream with results from the multi-cycle multiply/divide unit. The pipeline always has priority and is never stalled. Multi-cycle results are queued in a small FIFO with valid/ready handshake, and older queued writes are squashed when the pipeline overwrites the same register. It also reports pending writes per read port so the hazard unit can stall dependent reads.

## Interface
- DEPTH, 4, FIFO entries for secondary writes (power of two, 2..16)
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  synchronous active-high reset
- pwe  in  1  primary (pipeline) write enable, this cycle
- pwn  in  5  primary destination register
- pd  in  32  primary write data
- svalid  in  1  secondary (multi-cycle unit) write request
- swn  in  5  secondary destination register
- sd  in  32  secondary write data
- sready  out  1  secondary request accepted when svalid && sready
- rna  in  5  read-port A register number (hazard query)
- rnb  in  5  read-port B register number (hazard query)
- pend_a  out  1  live queued write targets rna
- pend_b  out  1  live queued write targets rnb
- we  out  1  register-file write enable (registered)
- wn  out  5  register-file write register (registered)
- d  out  32  register-file write data (registered)

## Operation
- FIFO: DEPTH entries of {live, wn[4:0], d[31:0]}, with head/tail pointers wrapping mod DEPTH and count 0..DEPTH.
- sready = !clr && (count != DEPTH). It depends only on current count and is not relieved by a same-cycle pop.
- Accept (svalid && sready):
  - swn == 0: the request is accepted and discarded. It is not enqueued.
  - Otherwise it is enqueued at tail with live=1.
  - Exception: live=0 if pwe && pwn == swn in the same cycle. The queued entry counts as older than the primary.
- Squash: when pwe && pwn != 0, every FIFO entry with wn == pwn has live cleared at that edge. The entry still occupies its slot.
- Issue decision, evaluated each cycle on pre-edge state:
  - Primary: pwe && pwn != 0 loads {we=1, wn=pwn, d=pd}. There is no pop.
  - Otherwise, if count != 0: pop the head. Load {we=head.live, wn=head.wn, d=head.d}.
    - A dead head consumes the slot and issues we=0.
  - Otherwise: we=0, and wn/d hold their previous values.
- pwe with pwn == 0 counts as idle, so the FIFO may pop that cycle.
- Simultaneous push and pop update count by +0; a push when count==DEPTH-1 with pop is legal.
- pend_a = (rna != 0) && any live entry with wn == rna. This uses pre-edge state.
  - It also includes the incoming accepted-and-live secondary (svalid && sready && swn == rna).
- pend_b is the same with rnb.
- pend_a/pend_b do not reflect the output register; the register file write happens at the next edge, and pipeline forwarding covers it.

## Timing
- Reset: on clr at a rising edge, count=0, pointers=0, all live=0, we=0, wn=0, d=0.
  - While clr is high: sready=0, pend_a=pend_b=0.
  - clr mid-operation discards all queued writes. An in-flight output write is dropped (we=0 after the edge).
- Primary latency: pwe sampled at edge E gives we=1 during the cycle after E. The register file writes at E+1.
- Secondary latency, FIFO empty and pipeline idle: accepted at E, popped at E+1, we=1 after E+1. That is 2 cycles.
- Secondary throughput: one pop per primary-idle cycle. Sustained pwe starves the FIFO, which is acceptable by design; sready throttles the unit.
- Write order to any register matches program order: primary writes always win over older queued writes to the same register.

## Test plan
- Reset/idle: clr for 2 cycles with svalid=1 -> sready=0, we=0, wn=0, d=0; release -> sready=1, pend_a=pend_b=0.
- Primary: pwe=1, pwn=5, pd=0xDEADBEEF at E -> we=1, wn=5, d=0xDEADBEEF after E; pwn=0 -> we stays 0.
- Queue and backpressure:
  - Stimulus: hold pwe=1 (pwn=7) for 6 cycles while svalid=1 with swn=1..4.
  - Response: 4 accepted, then sready=0.
  - On release: we pulses wn=1,2,3,4 on 4 consecutive cycles, then sready=1.
- Squash:
  - Stimulus: queue swn=9, sd=0x11. Next cycle pwe=1, pwn=9, pd=0x22.
  - Response: we wn=9 d=0x22, then a dead pop with we=0; the final r9 value is 0x22.
  - pend_a with rna=9 goes 1 -> 0 at the squash edge.
- Same-cycle conflict: svalid swn=3 sd=0xA and pwe pwn=3 pd=0xB together -> entry dead, only write is 0xB; swn=0 accepted -> never issued, count unchanged.
- Mid-operation reset: 3 entries queued, clr for 1 cycle -> count=0, we=0, no queued register written afterward.
